// File: rtl/vgm_fm_seq.sv
// VGM command sequencer: parses a VGM byte stream and turns register-write
// opcodes into spaced jt10 bus cycles, times wait opcodes against the
// 44.1 kHz sample strobe, and stops on end-of-stream or an unknown opcode.
module vgm_fm_seq #(
    parameter int WR_GAP = 8,
    parameter int WAIT_W = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       start,
    input  logic [7:0] st_data,
    input  logic       st_valid,
    output logic       st_ready,
    input  logic       sample_tick,
    output logic [1:0] fm_addr,
    output logic [7:0] fm_din,
    output logic       fm_wr_n,
    output logic       busy,
    output logic       done,
    output logic       bad_cmd
);

    typedef enum logic [3:0] {
        IDLE,
        FETCH_CMD,
        FETCH_ARG,
        WR_ADDR,
        GAP_A,
        WR_DATA,
        GAP_D,
        WAIT,
        DONE
    } state_t;

    localparam int GAP_W = (WR_GAP > 1) ? $clog2(WR_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(WR_GAP - 1);

    state_t            state, state_nxt;
    logic              st_ready_nxt;
    logic [1:0]        fm_addr_nxt;
    logic [7:0]        fm_din_nxt;
    logic              fm_wr_n_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              bad_cmd_nxt;
    logic [WAIT_W-1:0] wait_cnt, wait_cnt_nxt;
    logic [GAP_W-1:0]  gap_cnt, gap_cnt_nxt;
    logic              arg_cnt, arg_cnt_nxt;
    logic              port, port_nxt;
    logic              is_wait, is_wait_nxt;
    logic [7:0]        arg0, arg0_nxt;
    logic [7:0]        val, val_nxt;
    logic              take;

    assign take = st_valid && st_ready;

    // Control state and bus outputs; everything returns to idle values on rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            st_ready <= 1'b0;
            fm_addr  <= 2'd0;
            fm_din   <= 8'd0;
            fm_wr_n  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            bad_cmd  <= 1'b0;
            wait_cnt <= '0;
            gap_cnt  <= '0;
            arg_cnt  <= 1'b0;
            port     <= 1'b0;
            is_wait  <= 1'b0;
        end else begin
            state    <= state_nxt;
            st_ready <= st_ready_nxt;
            fm_addr  <= fm_addr_nxt;
            fm_din   <= fm_din_nxt;
            fm_wr_n  <= fm_wr_n_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
            bad_cmd  <= bad_cmd_nxt;
            wait_cnt <= wait_cnt_nxt;
            gap_cnt  <= gap_cnt_nxt;
            arg_cnt  <= arg_cnt_nxt;
            port     <= port_nxt;
            is_wait  <= is_wait_nxt;
        end
    end

    // Argument bytes are pure data and are always overwritten before use.
    always_ff @(posedge clk) begin
        arg0 <= arg0_nxt;
        val  <= val_nxt;
    end

    // Next-state decode: opcode parsing, write sequencing and wait timing.
    always_comb begin
        state_nxt    = state;
        fm_addr_nxt  = fm_addr;
        fm_din_nxt   = fm_din;
        fm_wr_n_nxt  = fm_wr_n;
        busy_nxt     = busy;
        done_nxt     = done;
        bad_cmd_nxt  = bad_cmd;
        wait_cnt_nxt = wait_cnt;
        gap_cnt_nxt  = gap_cnt;
        arg_cnt_nxt  = arg_cnt;
        port_nxt     = port;
        is_wait_nxt  = is_wait;
        arg0_nxt     = arg0;
        val_nxt      = val;

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt   = FETCH_CMD;
                    done_nxt    = 1'b0;
                    bad_cmd_nxt = 1'b0;
                    busy_nxt    = 1'b1;
                end
            end
            FETCH_CMD: begin
                if (take) begin
                    arg_cnt_nxt = 1'b0;
                    case (st_data)
                        8'h58, 8'h59: begin
                            port_nxt    = st_data[0];
                            is_wait_nxt = 1'b0;
                            state_nxt   = FETCH_ARG;
                        end
                        8'h61: begin
                            is_wait_nxt = 1'b1;
                            state_nxt   = FETCH_ARG;
                        end
                        8'h62: begin
                            wait_cnt_nxt = WAIT_W'(735);
                            state_nxt    = WAIT;
                        end
                        8'h63: begin
                            wait_cnt_nxt = WAIT_W'(882);
                            state_nxt    = WAIT;
                        end
                        8'h66: begin
                            done_nxt  = 1'b1;
                            busy_nxt  = 1'b0;
                            state_nxt = DONE;
                        end
                        default: begin
                            if (st_data[7:4] == 4'h7) begin
                                wait_cnt_nxt = WAIT_W'(st_data[3:0]) + WAIT_W'(1);
                                state_nxt    = WAIT;
                            end else begin
                                bad_cmd_nxt = 1'b1;
                                busy_nxt    = 1'b0;
                                state_nxt   = DONE;
                            end
                        end
                    endcase
                end
            end
            FETCH_ARG: begin
                if (take) begin
                    if (!arg_cnt) begin
                        arg0_nxt    = st_data;
                        arg_cnt_nxt = 1'b1;
                    end else if (is_wait) begin
                        // Little-endian: arg0 holds the low byte.
                        if ({st_data, arg0} == 16'd0) begin
                            state_nxt = FETCH_CMD;
                        end else begin
                            wait_cnt_nxt = WAIT_W'({st_data, arg0});
                            state_nxt    = WAIT;
                        end
                    end else begin
                        val_nxt     = st_data;
                        fm_addr_nxt = {port, 1'b0};
                        fm_din_nxt  = arg0;
                        fm_wr_n_nxt = 1'b0;
                        state_nxt   = WR_ADDR;
                    end
                end
            end
            WR_ADDR: begin
                // jt10 samples the bus on this cen edge; release strobe with it.
                if (cen) begin
                    fm_wr_n_nxt = 1'b1;
                    gap_cnt_nxt = '0;
                    state_nxt   = GAP_A;
                end
            end
            GAP_A: begin
                if (cen) begin
                    if (gap_cnt == GAP_LAST) begin
                        fm_addr_nxt = {port, 1'b1};
                        fm_din_nxt  = val;
                        fm_wr_n_nxt = 1'b0;
                        state_nxt   = WR_DATA;
                    end else begin
                        gap_cnt_nxt = gap_cnt + GAP_W'(1);
                    end
                end
            end
            WR_DATA: begin
                if (cen) begin
                    fm_wr_n_nxt = 1'b1;
                    gap_cnt_nxt = '0;
                    state_nxt   = GAP_D;
                end
            end
            GAP_D: begin
                if (cen) begin
                    if (gap_cnt == GAP_LAST) begin
                        state_nxt = FETCH_CMD;
                    end else begin
                        gap_cnt_nxt = gap_cnt + GAP_W'(1);
                    end
                end
            end
            WAIT: begin
                // Leaving on the tick that consumes the last sample gives exactly N ticks.
                if (sample_tick) begin
                    wait_cnt_nxt = wait_cnt - WAIT_W'(1);
                    if (wait_cnt == WAIT_W'(1)) begin
                        state_nxt = FETCH_CMD;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        st_ready_nxt = (state_nxt == FETCH_CMD) || (state_nxt == FETCH_ARG);
    end

endmodule
